// File: rtl/ex_stage_if.sv
// Execute-stage bus: ID/EX operands and controls in, EX/MEM register contents out,
// plus forwarding selects and hazard-unit controls.
interface ex_stage_if;
    logic [15:0] RegA;
    logic [15:0] RegB;
    logic [15:0] Immediate;
    logic [15:0] PC;
    logic [2:0]  AluOp;
    logic        AluSrc;
    logic        SetFlags;
    logic        RegWr;
    logic [2:0]  Rd;
    logic [6:0]  MemSignals;
    logic        ValidIn;
    logic [1:0]  FwdA;
    logic [1:0]  FwdB;
    logic [15:0] DataWB;
    logic        Stall;
    logic        Flush;

    logic [15:0] AluResult;
    logic [15:0] Immediate2;
    logic [15:0] PC2;
    logic [15:0] StoreData;
    logic [6:0]  signals;
    logic        RegWr2;
    logic [2:0]  Rd2;
    logic        Valid2;
    logic        Zero;
    logic        Negative;
    logic        Carry;

    modport master (
        output RegA, RegB, Immediate, PC, AluOp, AluSrc, SetFlags, RegWr, Rd,
               MemSignals, ValidIn, FwdA, FwdB, DataWB, Stall, Flush,
        input  AluResult, Immediate2, PC2, StoreData, signals, RegWr2, Rd2,
               Valid2, Zero, Negative, Carry
    );

    modport slave (
        input  RegA, RegB, Immediate, PC, AluOp, AluSrc, SetFlags, RegWr, Rd,
               MemSignals, ValidIn, FwdA, FwdB, DataWB, Stall, Flush,
        output AluResult, Immediate2, PC2, StoreData, signals, RegWr2, Rd2,
               Valid2, Zero, Negative, Carry
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, 16-bit ALU, EX/MEM pipeline register and
// condition-flag register, with stall/flush handling from the hazard unit.
module ex_stage (
    input  logic       clk,
    input  logic       reset,
    ex_stage_if.slave  ex
);
    logic [15:0] alu_result_q, alu_result_d;
    logic [15:0] immediate2_q, immediate2_d;
    logic [15:0] pc2_q, pc2_d;
    logic [15:0] store_data_q, store_data_d;
    logic [6:0]  signals_q, signals_d;
    logic        reg_wr2_q, reg_wr2_d;
    logic [2:0]  rd2_q, rd2_d;
    logic        valid2_q, valid2_d;
    logic        zero_q, zero_d;
    logic        negative_q, negative_d;
    logic        carry_q, carry_d;

    logic [15:0] op_a, fwd_b, op_b, alu_res;
    logic [16:0] sum;
    logic        alu_carry;

    always_comb begin
        case (ex.FwdA)
            2'd1:    op_a = alu_result_q;
            2'd2:    op_a = ex.DataWB;
            default: op_a = ex.RegA;
        endcase
        case (ex.FwdB)
            2'd1:    fwd_b = alu_result_q;
            2'd2:    fwd_b = ex.DataWB;
            default: fwd_b = ex.RegB;
        endcase
        op_b = ex.AluSrc ? ex.Immediate : fwd_b;
    end

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        sum       = '0;
        case (ex.AluOp)
            3'b000: alu_res = op_a & op_b;
            3'b001: begin
                sum       = {1'b0, op_a} + {1'b0, op_b};
                alu_res   = sum[15:0];
                alu_carry = sum[16];
            end
            3'b010: begin
                sum       = {1'b0, op_a} + {1'b0, ~op_b} + 17'd1;
                alu_res   = sum[15:0];
                alu_carry = sum[16];
            end
            3'b011: alu_res = op_a | op_b;
            3'b100: alu_res = op_a << op_b[3:0];
            3'b101: alu_res = op_a >> op_b[3:0];
            3'b110: alu_res = $signed(op_a) >>> op_b[3:0];
            3'b111: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Flush outranks Stall; a flushed or invalid slot carries no side-effect controls.
    always_comb begin
        alu_result_d = alu_result_q;
        immediate2_d = immediate2_q;
        pc2_d        = pc2_q;
        store_data_d = store_data_q;
        signals_d    = signals_q;
        reg_wr2_d    = reg_wr2_q;
        rd2_d        = rd2_q;
        valid2_d     = valid2_q;
        zero_d       = zero_q;
        negative_d   = negative_q;
        carry_d      = carry_q;
        if (ex.Flush) begin
            signals_d = '0;
            reg_wr2_d = 1'b0;
            valid2_d  = 1'b0;
        end else if (!ex.Stall) begin
            alu_result_d = alu_res;
            immediate2_d = ex.Immediate;
            pc2_d        = ex.PC;
            store_data_d = fwd_b;
            signals_d    = ex.ValidIn ? ex.MemSignals : '0;
            reg_wr2_d    = ex.RegWr & ex.ValidIn;
            rd2_d        = ex.Rd;
            valid2_d     = ex.ValidIn;
            if (ex.ValidIn && ex.SetFlags) begin
                zero_d     = (alu_res == '0);
                negative_d = alu_res[15];
                carry_d    = alu_carry;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result_q <= '0;
            immediate2_q <= '0;
            pc2_q        <= '0;
            store_data_q <= '0;
            signals_q    <= '0;
            reg_wr2_q    <= 1'b0;
            rd2_q        <= '0;
            valid2_q     <= 1'b0;
            zero_q       <= 1'b0;
            negative_q   <= 1'b0;
            carry_q      <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            immediate2_q <= immediate2_d;
            pc2_q        <= pc2_d;
            store_data_q <= store_data_d;
            signals_q    <= signals_d;
            reg_wr2_q    <= reg_wr2_d;
            rd2_q        <= rd2_d;
            valid2_q     <= valid2_d;
            zero_q       <= zero_d;
            negative_q   <= negative_d;
            carry_q      <= carry_d;
        end
    end

    assign ex.AluResult  = alu_result_q;
    assign ex.Immediate2 = immediate2_q;
    assign ex.PC2        = pc2_q;
    assign ex.StoreData  = store_data_q;
    assign ex.signals    = signals_q;
    assign ex.RegWr2     = reg_wr2_q;
    assign ex.Rd2        = rd2_q;
    assign ex.Valid2     = valid2_q;
    assign ex.Zero       = zero_q;
    assign ex.Negative   = negative_q;
    assign ex.Carry      = carry_q;
endmodule
